ccff_chain_loader: RTL

- Configuration-chain controller that serializes a word-wide bitstream into a tile's ccff_head/ccff_tail chain, which runs on prog_clk.
- Accepts words over a valid/ready interface and emits exactly CHAIN_LEN bits, LSB first.
- Asserts a shift enable that gates the chain's prog_clk, then signals completion.
- Sits between the bitstream source (JTAG/SPI front end) and the first tile's ccff_head.

---
 rtl/ccff_chain_loader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: takes bitstream words over valid/ready and shifts CHAIN_LEN bits LSB-first into ccff_head.
// Define CCFF_READBACK_EN to add readback_crc, a CRC-16-CCITT of ccff_tail taken while the chain shifts.
module ccff_chain_loader #(
  parameter  int CHAIN_LEN = 26,
  parameter  int WORD_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  bit_count
`ifdef CCFF_READBACK_EN
  ,
  output logic [15:0]       readback_crc
`endif
);

  localparam int WL_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WL_W-1:0]  WL_FULL  = WL_W'(WORD_W);
  localparam logic [WL_W-1:0]  WL_ONE   = WL_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [WL_W-1:0]   word_left_q, word_left_d;
  logic [CNT_W-1:0]  bit_count_q, bit_count_d;
  logic              aborted_q, aborted_d;
  logic              crc_init;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      word_left_q <= '0;
      bit_count_q <= '0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      word_left_q <= word_left_d;
      bit_count_q <= bit_count_d;
      aborted_q   <= aborted_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    sreg_d        = sreg_q;
    word_left_d   = word_left_q;
    bit_count_d   = bit_count_q;
    aborted_d     = 1'b0;
    cfg_ready     = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    crc_init      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = FETCH;
          bit_count_d = '0;
          crc_init    = 1'b1;
        end
      end
      FETCH: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else begin
          cfg_ready = 1'b1;
          if (cfg_valid) begin
            sreg_d      = cfg_data;
            word_left_d = WL_FULL;
            state_d     = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else begin
          ccff_shift_en = 1'b1;
          ccff_head     = sreg_q[0];
          sreg_d        = sreg_q >> 1;
          word_left_d   = word_left_q - WL_ONE;
          bit_count_d   = bit_count_q + 1'b1;
          // Completion wins over refilling: leftover bits of the last word are dropped.
          if (bit_count_q == LAST_BIT) begin
            state_d = DONE;
          end else if (word_left_q == WL_ONE) begin
            cfg_ready = 1'b1;
            if (cfg_valid) begin
              sreg_d      = cfg_data;
              word_left_d = WL_FULL;
            end else begin
              state_d = FETCH;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign aborted   = aborted_q;
  assign bit_count = bit_count_q;

`ifdef CCFF_READBACK_EN
  logic [15:0] crc_q, crc_d;
  logic        crc_fb;

  always_comb begin
    crc_fb = crc_q[15] ^ ccff_tail;
    crc_d  = crc_q;
    if (crc_init) begin
      crc_d = 16'hFFFF;
    end else if (ccff_shift_en) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
    end
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      crc_q <= 16'hFFFF;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign readback_crc = crc_q;
`else
  logic unused_readback;
  assign unused_readback = ccff_tail ^ crc_init;
`endif

endmodule
